// File: rtl/intc_pkg.sv
// Shared types and helpers for the priority interrupt controller.
// Optional nesting is enabled with INTC_NESTING_EN.
package intc_pkg;

  localparam int N_IRQ_DEF = 8;
  localparam int VEC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Caller truncates to its vector width, giving modulo wrap.
  function automatic logic [31:0] vec_of(
    input logic [31:0] base,
    input logic [31:0] idx
  );
    return base + idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side request/acknowledge bundle of the interrupt controller.
// master = controller, slave = CPU.
interface interrupt_controller_if #(
  parameter int VEC_W = 16
);

  logic             int_req;
  logic [VEC_W-1:0] int_vector;
  logic             int_ack;
  logic             eoi;

  modport master (
    output int_req,
    output int_vector,
    input  int_ack,
    input  eoi
  );

  modport slave (
    input  int_req,
    input  int_vector,
    output int_ack,
    output eoi
  );

endinterface

// File: rtl/interrupt_controller_prio_enc.sv
// Lowest-index-first priority encoder.
// Used for request selection and lowest in-service lookup.
module prio_enc #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/interrupt_controller.sv
// Priority interrupt controller with edge capture, mask and req/ack/eoi.
// Define INTC_NESTING_EN to allow higher-priority preemption in SERVICE.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int               N_IRQ      = N_IRQ_DEF,
  parameter int               VEC_W      = VEC_W_DEF,
  parameter logic [VEC_W-1:0] VEC_BASE   = 16'h0010,
  parameter logic [N_IRQ-1:0] MASK_RESET = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IRQ-1:0]        irq_in,
  input  logic                    mask_we,
  input  logic [N_IRQ-1:0]        mask_wdata,
  output logic [N_IRQ-1:0]        mask_q,
  output logic [N_IRQ-1:0]        pending,
  output logic [N_IRQ-1:0]        in_service,
  interrupt_controller_if.master  cpu
);

  localparam int IW = $clog2(N_IRQ);

  state_e           state_q, state_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic             req_q, req_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] insv_q, insv_d;
  logic [N_IRQ-1:0] prev_q, prev_d;
  logic [N_IRQ-1:0] mask_d;
  logic [N_IRQ-1:0] clr_pend;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] cand;
  logic             cand_v;
  logic [IW-1:0]    cand_idx;
  logic [VEC_W-1:0] cand_vec;

  assign rise = irq_in & ~prev_q;
  assign cand = pend_q & mask_q;
  assign cand_vec =
    VEC_W'(vec_of(32'(VEC_BASE), 32'(cand_idx)));

  prio_enc #(.N(N_IRQ), .IW(IW)) u_cand (
    .req   (cand),
    .valid (cand_v),
    .idx   (cand_idx)
  );

`ifdef INTC_NESTING_EN
  logic          svc_v;
  logic [IW-1:0] svc_idx;

  prio_enc #(.N(N_IRQ), .IW(IW)) u_svc (
    .req   (insv_q),
    .valid (svc_v),
    .idx   (svc_idx)
  );
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    req_d    = req_q;
    vec_d    = vec_q;
    insv_d   = insv_q;
    clr_pend = '0;
    prev_d   = irq_in;
    mask_d   = mask_we ? mask_wdata : mask_q;
    case (state_q)
      IDLE: begin
        if (cand_v) begin
          state_d = REQ;
          sel_d   = cand_idx;
          req_d   = 1'b1;
          vec_d   = cand_vec;
        end
      end
      REQ: begin
        if (cpu.int_ack) begin
          clr_pend[sel_q] = 1'b1;
          insv_d[sel_q]   = 1'b1;
          req_d           = 1'b0;
          state_d         = SERVICE;
        end
      end
      SERVICE: begin
`ifdef INTC_NESTING_EN
        if (cpu.eoi) begin
          if (svc_v) insv_d[svc_idx] = 1'b0;
          if (insv_d == '0) state_d = IDLE;
        end else if (cand_v && (!svc_v || cand_idx < svc_idx)) begin
          state_d = REQ;
          sel_d   = cand_idx;
          req_d   = 1'b1;
          vec_d   = cand_vec;
        end
`else
        if (cpu.eoi) begin
          insv_d[sel_q] = 1'b0;
          state_d       = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the acked line must survive its clear.
    pend_d = (pend_q & ~clr_pend) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      req_q   <= 1'b0;
      vec_q   <= VEC_BASE;
      pend_q  <= '0;
      insv_q  <= '0;
      prev_q  <= '0;
      mask_q  <= MASK_RESET;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      pend_q  <= pend_d;
      insv_q  <= insv_d;
      prev_q  <= prev_d;
      mask_q  <= mask_d;
    end
  end

  assign pending        = pend_q;
  assign in_service     = insv_q;
  assign cpu.int_req    = req_q;
  assign cpu.int_vector = vec_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
// Nesting scenario runs only when INTC_NESTING_EN is defined.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask_q;
  logic [7:0] pending;
  logic [7:0] in_service;

  int n_pass  = 0;
  int n_total = 0;

  interrupt_controller_if #(.VEC_W(16)) cpu_if ();

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .pending    (pending),
    .in_service (in_service),
    .cpu        (cpu_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    cpu_if.int_ack = 1'b1;
    tick();
    cpu_if.int_ack = 1'b0;
  endtask

  task automatic end_irq();
    cpu_if.eoi = 1'b1;
    tick();
    cpu_if.eoi = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_in = v;
    tick();
    irq_in = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_total++;
    if (pending !== 8'h00 || in_service !== 8'h00)
      $display("FAIL rst_state pend=%h insv=%h exp 00/00",
               pending, in_service);
    else n_pass++;
    n_total++;
    if (mask_q !== 8'hFF || cpu_if.int_req !== 1'b0 ||
        cpu_if.int_vector !== 16'h0010)
      $display("FAIL rst_out mask=%h req=%b vec=%h exp ff/0/0010",
               mask_q, cpu_if.int_req, cpu_if.int_vector);
    else n_pass++;
  endtask

  task automatic test_single();
    pulse(8'h08);
    n_total++;
    if (pending !== 8'h08 || cpu_if.int_req !== 1'b0)
      $display("FAIL t1_pend pend=%h req=%b exp 08/0",
               pending, cpu_if.int_req);
    else n_pass++;
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b1 || cpu_if.int_vector !== 16'h0013)
      $display("FAIL t1_req req=%b vec=%h exp 1/0013",
               cpu_if.int_req, cpu_if.int_vector);
    else n_pass++;
    ack();
    n_total++;
    if (pending !== 8'h00 || in_service !== 8'h08 ||
        cpu_if.int_req !== 1'b0)
      $display("FAIL t1_ack pend=%h insv=%h req=%b exp 00/08/0",
               pending, in_service, cpu_if.int_req);
    else n_pass++;
    end_irq();
    n_total++;
    if (in_service !== 8'h00)
      $display("FAIL t1_eoi insv=%h exp 00", in_service);
    else n_pass++;
  endtask

  task automatic test_ignored();
    ack();
    end_irq();
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b0 || pending !== 8'h00 ||
        in_service !== 8'h00)
      $display("FAIL ign_idle req=%b pend=%h insv=%h exp 0/00/00",
               cpu_if.int_req, pending, in_service);
    else n_pass++;
  endtask

  task automatic test_priority();
    pulse(8'h24);
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b1 || cpu_if.int_vector !== 16'h0012)
      $display("FAIL t2_first req=%b vec=%h exp 1/0012",
               cpu_if.int_req, cpu_if.int_vector);
    else n_pass++;
    end_irq();
    n_total++;
    if (cpu_if.int_req !== 1'b1 || pending !== 8'h24 ||
        in_service !== 8'h00)
      $display("FAIL t2_eoi_in_req req=%b pend=%h insv=%h exp 1/24/00",
               cpu_if.int_req, pending, in_service);
    else n_pass++;
    ack();
    end_irq();
    n_total++;
    if (cpu_if.int_req !== 1'b0 || pending !== 8'h20)
      $display("FAIL t2_gap req=%b pend=%h exp 0/20",
               cpu_if.int_req, pending);
    else n_pass++;
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b1 || cpu_if.int_vector !== 16'h0015)
      $display("FAIL t2_second req=%b vec=%h exp 1/0015",
               cpu_if.int_req, cpu_if.int_vector);
    else n_pass++;
    ack();
    end_irq();
  endtask

  task automatic test_mask();
    mask_we    = 1'b1;
    mask_wdata = 8'hFE;
    tick();
    mask_we = 1'b0;
    n_total++;
    if (mask_q !== 8'hFE)
      $display("FAIL t3_mask mask=%h exp fe", mask_q);
    else n_pass++;
    pulse(8'h01);
    tick();
    tick();
    n_total++;
    if (pending !== 8'h01 || cpu_if.int_req !== 1'b0)
      $display("FAIL t3_masked pend=%h req=%b exp 01/0",
               pending, cpu_if.int_req);
    else n_pass++;
    mask_we    = 1'b1;
    mask_wdata = 8'hFF;
    tick();
    mask_we = 1'b0;
    n_total++;
    if (cpu_if.int_req !== 1'b0)
      $display("FAIL t3_oldmask req=%b exp 0", cpu_if.int_req);
    else n_pass++;
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b1 || cpu_if.int_vector !== 16'h0010)
      $display("FAIL t3_unmask req=%b vec=%h exp 1/0010",
               cpu_if.int_req, cpu_if.int_vector);
    else n_pass++;
    ack();
    end_irq();
  endtask

  task automatic test_level();
    irq_in = 8'h02;
    tick();
    tick();
    ack();
    repeat (7) tick();
    n_total++;
    if (pending !== 8'h00 || in_service !== 8'h02)
      $display("FAIL t4_level pend=%h insv=%h exp 00/02",
               pending, in_service);
    else n_pass++;
    end_irq();
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b0)
      $display("FAIL t4_onecap req=%b exp 0", cpu_if.int_req);
    else n_pass++;
    irq_in = 8'h00;
    tick();
    pulse(8'h02);
    tick();
    irq_in         = 8'h02;
    cpu_if.int_ack = 1'b1;
    tick();
    cpu_if.int_ack = 1'b0;
    irq_in         = 8'h00;
    n_total++;
    if (pending !== 8'h02 || in_service !== 8'h02)
      $display("FAIL t4_setwins pend=%h insv=%h exp 02/02",
               pending, in_service);
    else n_pass++;
    end_irq();
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b1 || cpu_if.int_vector !== 16'h0011)
      $display("FAIL t4_rereq req=%b vec=%h exp 1/0011",
               cpu_if.int_req, cpu_if.int_vector);
    else n_pass++;
    ack();
    end_irq();
  endtask

  task automatic test_reset_mid();
    pulse(8'h04);
    tick();
    ack();
    pulse(8'h10);
    mask_we    = 1'b1;
    mask_wdata = 8'h0F;
    tick();
    mask_we = 1'b0;
    n_total++;
    if (pending !== 8'h10 || in_service !== 8'h04 || mask_q !== 8'h0F)
      $display("FAIL t5_pre pend=%h insv=%h mask=%h exp 10/04/0f",
               pending, in_service, mask_q);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if (pending !== 8'h00 || in_service !== 8'h00 ||
        mask_q !== 8'hFF || cpu_if.int_req !== 1'b0 ||
        cpu_if.int_vector !== 16'h0010)
      $display("FAIL t5_reset pend=%h insv=%h mask=%h req=%b vec=%h",
               pending, in_service, mask_q, cpu_if.int_req,
               cpu_if.int_vector);
    else n_pass++;
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b0)
      $display("FAIL t5_lost req=%b exp 0", cpu_if.int_req);
    else n_pass++;
  endtask

`ifdef INTC_NESTING_EN
  task automatic test_nesting();
    pulse(8'h10);
    tick();
    ack();
    pulse(8'h40);
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b0)
      $display("FAIL t6_lowwait req=%b exp 0", cpu_if.int_req);
    else n_pass++;
    pulse(8'h02);
    tick();
    n_total++;
    if (cpu_if.int_req !== 1'b1 || cpu_if.int_vector !== 16'h0011)
      $display("FAIL t6_preempt req=%b vec=%h exp 1/0011",
               cpu_if.int_req, cpu_if.int_vector);
    else n_pass++;
    ack();
    n_total++;
    if (in_service !== 8'h12)
      $display("FAIL t6_insv insv=%h exp 12", in_service);
    else n_pass++;
    end_irq();
    n_total++;
    if (in_service !== 8'h10)
      $display("FAIL t6_eoi1 insv=%h exp 10", in_service);
    else n_pass++;
    end_irq();
    n_total++;
    if (in_service !== 8'h00)
      $display("FAIL t6_eoi2 insv=%h exp 00", in_service);
    else n_pass++;
    tick();
    ack();
    end_irq();
  endtask
`endif

  initial begin
    reset          = 1'b1;
    irq_in         = 8'h00;
    mask_we        = 1'b0;
    mask_wdata     = 8'h00;
    cpu_if.int_ack = 1'b0;
    cpu_if.eoi     = 1'b0;
    test_reset();
    test_single();
    test_ignored();
    test_priority();
    test_mask();
    test_level();
    test_reset_mid();
`ifdef INTC_NESTING_EN
    test_nesting();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
